// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS controller, ALU decoder and datapath
// Contents: state_t (FSM state codes), opcode constants, alusrcb/pcsrc/aluop code values.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU decode class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// rtl/mips_multicycle_controller_if.sv - controller <-> datapath signal bundle
// master: controller (drives controls, reads opcode/zero/mem_ready)
// slave : datapath / memory side (drives opcode/zero/mem_ready, reads controls)
interface mips_multicycle_controller_if;

    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        iord;
    logic        alusrca;
    logic        irwrite;
    logic        memwrite;
    logic        regwrite;
    logic        regdst;
    logic        memtoreg;
    logic        branch;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsrc;
    logic [1:0]  aluop;
    logic        pc_en;
    logic        illegal_op;
    logic [31:0] retired;
    logic [3:0]  state;

    modport master (
        input  opcode, zero, mem_ready,
        output iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, branch,
        output alusrcb, pcsrc, aluop, pc_en, illegal_op, retired, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, branch,
        input  alusrcb, pcsrc, aluop, pc_en, illegal_op, retired, state
    );

endinterface

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - Moore FSM controller for a multicycle MIPS datapath
// Ports: clk (rising edge), reset (sync, active-high), bus (master modport: opcode/zero/mem_ready
// in; datapath controls, pc_en, illegal_op, retired count and debug state out).
// MEM_HANDSHAKE=0 treats mem_ready as always 1.
module mips_multicycle_controller
    import mips_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    mips_multicycle_controller_if.master   bus
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] retired_q;

    logic        mem_rdy;
    logic        retire;
    logic        pcwrite;
    logic        iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, branch;
    logic [1:0]  alusrcb, pcsrc, aluop;
    logic        illegal_op;

    assign mem_rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        pcwrite    = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        branch     = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                irwrite = mem_rdy;
                pcwrite = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = SRCB_BOFF;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                iord = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWRITE: begin
                // request stays asserted for every wait cycle
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_rdy) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // reset overrides the state decode so an aborted instruction writes nothing
        if (reset) begin
            retire     = 1'b0;
            pcwrite    = 1'b0;
            iord       = 1'b0;
            alusrca    = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            branch     = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            aluop      = 2'b00;
            illegal_op = 1'b0;
        end
    end

    assign bus.iord       = iord;
    assign bus.alusrca    = alusrca;
    assign bus.irwrite    = irwrite;
    assign bus.memwrite   = memwrite;
    assign bus.regwrite   = regwrite;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.branch     = branch;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.aluop      = aluop;
    assign bus.pc_en      = pcwrite | (branch & bus.zero);
    assign bus.illegal_op = illegal_op;
    assign bus.retired    = retired_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - self-checking bench for mips_multicycle_controller
module tb_mips_multicycle_controller;

    logic clk;
    logic reset;

    mips_multicycle_controller_if bus();

    mips_multicycle_controller #(.MEM_HANDSHAKE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {iord,alusrca,irwrite,memwrite,regwrite,regdst,memtoreg,branch,alusrcb,pcsrc,aluop,pc_en,illegal_op}
    logic [15:0] act_ctl;
    assign act_ctl = {bus.iord, bus.alusrca, bus.irwrite, bus.memwrite, bus.regwrite,
                      bus.regdst, bus.memtoreg, bus.branch, bus.alusrcb, bus.pcsrc,
                      bus.aluop, bus.pc_en, bus.illegal_op};

    localparam logic [15:0] C_NONE    = 16'h0000;
    localparam logic [15:0] C_FETCH   = 16'h2042;
    localparam logic [15:0] C_FWAIT   = 16'h0040;
    localparam logic [15:0] C_DECODE  = 16'h00C0;
    localparam logic [15:0] C_ILLEGAL = 16'h00C1;
    localparam logic [15:0] C_MEMADR  = 16'h4080;
    localparam logic [15:0] C_MEMREAD = 16'h8000;
    localparam logic [15:0] C_MEMWB   = 16'h0A00;
    localparam logic [15:0] C_MEMWR   = 16'h9000;
    localparam logic [15:0] C_EXEC    = 16'h4008;
    localparam logic [15:0] C_ALUWB   = 16'h0C00;
    localparam logic [15:0] C_BR_NT   = 16'h4114;
    localparam logic [15:0] C_BR_T    = 16'h4116;
    localparam logic [15:0] C_ADDIEX  = 16'h4080;
    localparam logic [15:0] C_ADDIWB  = 16'h0800;
    localparam logic [15:0] C_JUMP    = 16'h0022;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        mrdy;
        logic [3:0]  exp_state;
        logic [15:0] exp_ctl;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic add(input logic rst, input logic [5:0] op, input logic z, input logic mrdy,
                       input logic [3:0] st, input logic [15:0] ctl, input logic [31:0] ret);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.mrdy = mrdy;
        v.exp_state = st; v.exp_ctl = ctl; v.exp_ret = ret;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic rst, input logic [5:0] op, input logic z, input logic mrdy);
        reset         = rst;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = mrdy;
    endtask

    initial begin
        drive(1'b1, LW, 1'b0, 1'b1);
        step();

        // reset held with lw opcode present
        add(1, LW, 0, 1, 0, C_NONE, 0);
        add(1, LW, 0, 1, 0, C_NONE, 0);
        add(1, LW, 0, 1, 0, C_NONE, 0);
        // lw, no waits
        add(0, LW, 0, 1, 0, C_FETCH,   0);
        add(0, LW, 0, 1, 1, C_DECODE,  0);
        add(0, LW, 0, 1, 2, C_MEMADR,  0);
        add(0, LW, 0, 1, 3, C_MEMREAD, 0);
        add(0, LW, 0, 1, 4, C_MEMWB,   0);
        // sw with two wait cycles in MEMWRITE
        add(0, SW, 0, 1, 0, C_FETCH,  1);
        add(0, SW, 0, 1, 1, C_DECODE, 1);
        add(0, SW, 0, 1, 2, C_MEMADR, 1);
        add(0, SW, 0, 0, 5, C_MEMWR,  1);
        add(0, SW, 0, 0, 5, C_MEMWR,  1);
        add(0, SW, 0, 1, 5, C_MEMWR,  1);
        // beq taken, with a fetch wait cycle first
        add(0, BEQ, 1, 0, 0, C_FWAIT,  2);
        add(0, BEQ, 1, 1, 0, C_FETCH,  2);
        add(0, BEQ, 1, 1, 1, C_DECODE, 2);
        add(0, BEQ, 1, 1, 8, C_BR_T,   2);
        // beq not taken
        add(0, BEQ, 0, 1, 0, C_FETCH,  3);
        add(0, BEQ, 0, 1, 1, C_DECODE, 3);
        add(0, BEQ, 0, 1, 8, C_BR_NT,  3);
        // R-type
        add(0, RT, 0, 1, 0, C_FETCH,  4);
        add(0, RT, 0, 1, 1, C_DECODE, 4);
        add(0, RT, 0, 1, 6, C_EXEC,   4);
        add(0, RT, 0, 1, 7, C_ALUWB,  4);
        // addi
        add(0, ADDI, 0, 1, 0,  C_FETCH,  5);
        add(0, ADDI, 0, 1, 1,  C_DECODE, 5);
        add(0, ADDI, 0, 1, 9,  C_ADDIEX, 5);
        add(0, ADDI, 0, 1, 10, C_ADDIWB, 5);
        // illegal opcode
        add(0, BAD, 0, 1, 0, C_FETCH,   6);
        add(0, BAD, 0, 1, 1, C_ILLEGAL, 6);
        // j
        add(0, JMP, 0, 1, 0,  C_FETCH,  6);
        add(0, JMP, 0, 1, 1,  C_DECODE, 6);
        add(0, JMP, 0, 1, 11, C_JUMP,   6);
        // sw aborted by reset in MEMWRITE
        add(0, SW, 0, 1, 0, C_FETCH,  7);
        add(0, SW, 0, 1, 1, C_DECODE, 7);
        add(0, SW, 0, 1, 2, C_MEMADR, 7);
        add(1, SW, 0, 1, 5, C_NONE,   7);
        add(0, SW, 0, 1, 0, C_FETCH,  0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mrdy);
            #1;
            chk($sformatf("v%0d state", i),   {28'd0, bus.state}, {28'd0, vecs[i].exp_state});
            chk($sformatf("v%0d ctl", i),     {16'd0, act_ctl},   {16'd0, vecs[i].exp_ctl});
            chk($sformatf("v%0d retired", i), bus.retired,        vecs[i].exp_ret);
            step();
        end

        // retired wrap: preload all-ones, then retire a j
        drive(1'b1, JMP, 1'b0, 1'b1);
        step();
        drive(1'b0, JMP, 1'b0, 1'b1);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        chk("wrap preload", bus.retired, 32'hFFFF_FFFF);
        step();
        step();
        #1;
        chk("wrap in jump state", {28'd0, bus.state}, 32'd11);
        step();
        #1;
        chk("wrap retired", bus.retired, 32'd0);
        chk("wrap back to fetch", {28'd0, bus.state}, 32'd0);

        // reset asserted in EXECUTE
        drive(1'b0, RT, 1'b0, 1'b1);
        step();
        step();
        #1;
        chk("rst-exec state", {28'd0, bus.state}, 32'd6);
        reset = 1'b1;
        #1;
        chk("rst-exec regwrite", {31'd0, bus.regwrite}, 32'd0);
        chk("rst-exec ctl", {16'd0, act_ctl}, 32'd0);
        step();
        #1;
        chk("rst-exec next state", {28'd0, bus.state}, 32'd0);
        chk("rst-exec no regwrite after", {31'd0, bus.regwrite}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post-reset fetch ctl", {16'd0, act_ctl}, {16'd0, C_FETCH});
        chk("post-reset retired", bus.retired, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_controller.md
MIPS_MULTICYCLE_CONTROLLER -- requirements
Module: mips_multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1; 0 = mem_ready ignored and treated as 1.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 opcode  in  6  instr[31:26] from the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory access completes this cycle.
REQ-007 iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, branch  out  1 each  datapath controls.
REQ-008 alusrcb, pcsrc, aluop  out  2 each  mux selects and ALU decode class.
REQ-009 pc_en  out  1  = pcwrite | (branch & zero), combinational.
REQ-010 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-011 retired  out  32  retired-instruction count.
REQ-012 state  out  4  current state encoding, for debug.

Function
REQ-013 Moore FSM SHALL use encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH.
REQ-014 FETCH SHALL drive iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready. It holds until mem_ready, then goes to DECODE.
REQ-015 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
  - 100011 (lw) / 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEXEC
  - 000010 (j) -> JUMP
  - any other -> FETCH, with illegal_op=1 for that cycle
REQ-016 MEMADR SHALL drive alusrca=1, alusrcb=10, aluop=00; lw -> MEMREAD, sw -> MEMWRITE.
REQ-017 MEMREAD SHALL drive iord=1 and hold until mem_ready, then go to MEMWB. MEMWB SHALL drive regdst=0, memtoreg=1, regwrite=1, then go to FETCH.
REQ-018 MEMWRITE SHALL drive iord=1 and memwrite=1 on every cycle in the state (request held). It holds until mem_ready, then goes to FETCH.
REQ-019 EXECUTE SHALL drive alusrca=1, alusrcb=00, aluop=10, then go to ALUWB. ALUWB SHALL drive regdst=1, memtoreg=0, regwrite=1, then go to FETCH.
REQ-020 BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, then go to FETCH.
REQ-021 ADDIEXEC SHALL drive alusrca=1, alusrcb=10, aluop=00, then go to ADDIWB. ADDIWB SHALL drive regdst=0, memtoreg=0, regwrite=1, then go to FETCH.
REQ-022 JUMP SHALL drive pcsrc=10 and pcwrite=1, then go to FETCH.
REQ-023 Every output not listed for a state SHALL be 0.
REQ-024 Latencies with mem_ready tied to 1 SHALL be: lw 5 cycles; sw, R-type, addi 4; beq, j 3.
REQ-025 Each memory wait cycle SHALL add exactly 1 cycle.
REQ-026 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB or JUMP. It SHALL NOT increment on an illegal opcode and SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 opcode SHALL be sampled only in DECODE and MEMADR; it is don't-care elsewhere.

Reset
REQ-028 While reset=1, state SHALL load FETCH, retired SHALL load 0, and all control outputs SHALL be forced to 0, overriding state decode.
REQ-029 A reset asserted mid-instruction SHALL abort the instruction with no regwrite or memwrite in the reset cycle. The first post-reset cycle SHALL be FETCH.

Structure
REQ-030 The state encodings, opcode constants and alusrcb/pcsrc/aluop code values SHALL live in a shared package (mips_pkg) reused by the ALU decoder and datapath.
REQ-031 The design SHALL be a single module with no sub-module; next-state and output decode are combinational, and the state and counter are registered.

Verification
REQ-032 Bench SHALL cover:
  - reset held 3 cycles while opcode=100011 -> state=0, all controls 0, retired=0.
  - lw, mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 only in state 4; retired=1.
  - sw with mem_ready low 2 cycles in MEMWRITE -> memwrite=1 for 3 cycles, then FETCH.
  - beq with zero=1 -> pc_en=1 in BRANCH; with zero=0 -> pc_en=0 in BRANCH.
  - opcode=111111 -> illegal_op pulse in DECODE, back to FETCH, retired unchanged.
  - retired forced to 0xFFFFFFFF, then a j instruction -> retired=0; reset asserted in EXECUTE -> next state 0, no regwrite.
